uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter between NUM_REQ requesters using round-robin arbitration.
- Each requester uses a valid/ready handshake. The block accepts one word, then holds it stable on the UART data input.
- It pulses the UART start input and waits for the UART done pulse, then inserts one gap cycle before the next arbitration.
- A watchdog recovers from a UART that never signals done.

---
 rtl/uart_tx_arbiter.sv | 106 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between NUM_REQ
// valid/ready requesters, with a WAIT-state watchdog for a silent UART.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                     tx_clk,
  input  logic                     tx_reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     uart_start,
  output logic [WIDTH-1:0]         uart_data,
  input  logic                     uart_done,
  output logic                     busy,
  output logic [ID_W-1:0]          grant_id,
  output logic                     timeout_err
);

  localparam int              TW   = $clog2(TIMEOUT);
  localparam logic [TW-1:0]   TMAX = TW'(TIMEOUT - 1);
  localparam logic [ID_W+1:0] NREQ = (ID_W + 2)'(NUM_REQ);

  typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;

  state_t                 state;
  logic [ID_W-1:0]        last_grant;
  logic [TW-1:0]          timer;
  logic                   any_valid;
  logic [2*NUM_REQ-1:0]   valid_dbl;
  logic [NUM_REQ-1:0]     valid_rot;
  logic [ID_W+1:0]        base;
  logic [ID_W+1:0]        offset;
  logic [ID_W+1:0]        sum;
  logic [ID_W-1:0]        winner;

  // Rotate the request vector so bit 0 is the slot after last_grant, then
  // take the lowest set bit and map it back to an absolute index.
  always_comb begin
    any_valid = |req_valid;
    valid_dbl = {req_valid, req_valid};
    base      = {2'b00, last_grant} + (ID_W + 2)'(1);
    valid_rot = NUM_REQ'(valid_dbl >> base);
    offset    = '0;
    for (int unsigned i = NUM_REQ; i > 0; i--) begin
      if (valid_rot[i-1]) offset = (ID_W + 2)'(i - 1);
    end
    sum = base + offset;
    if (sum >= NREQ) sum = sum - NREQ;
    winner    = sum[ID_W-1:0];
    req_ready = '0;
    if (state == IDLE && any_valid) req_ready[winner] = 1'b1;
  end

  // uart_start and busy are registered on the same edges that enter START
  // and leave GAP, so they match a pure state decode cycle for cycle.
  always_ff @(posedge tx_clk or posedge tx_reset) begin
    if (tx_reset) begin
      state       <= IDLE;
      last_grant  <= ID_W'(NUM_REQ - 1);
      timer       <= '0;
      uart_start  <= 1'b0;
      uart_data   <= '0;
      busy        <= 1'b0;
      grant_id    <= '0;
      timeout_err <= 1'b0;
    end else begin
      uart_start  <= 1'b0;
      timeout_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_valid) begin
            uart_data  <= req_data[winner*WIDTH +: WIDTH];
            grant_id   <= winner;
            last_grant <= winner;
            uart_start <= 1'b1;
            busy       <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (uart_done) begin
            state <= GAP;
          end else if (timer == TMAX) begin
            timeout_err <= 1'b1;
            state       <= GAP;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        GAP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a frame-level timing model predicts
// every output each cycle under directed and randomized requester traffic.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int IDW = 2;
  localparam int TO  = 64;
  localparam int NEVER = 1000;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   valid = '0;
  logic [N*W-1:0] data = '0;
  logic [N-1:0]   ready;
  logic           start;
  logic [W-1:0]   udata;
  logic           done = 1'b0;
  logic           busy;
  logic [IDW-1:0] gid;
  logic           terr;

  uart_tx_arbiter #(.NUM_REQ(N), .WIDTH(W), .ID_W(IDW), .TIMEOUT(TO)) dut (
    .tx_clk(clk), .tx_reset(rst), .req_valid(valid), .req_data(data),
    .req_ready(ready), .uart_start(start), .uart_data(udata),
    .uart_done(done), .busy(busy), .grant_id(gid), .timeout_err(terr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Frame-level model: each accepted word occupies START, a WAIT window
  // ending on done or on the watchdog, then one GAP cycle.
  int cyc, last_g, start_c, wait_end, gap_c, free_at, done_c, exp_gid, lat_mode;
  bit to_flag, keep_valid, auto_gen, spurious;
  logic [W-1:0] exp_data;
  logic [W-1:0] word [N];
  logic [N-1:0] vld = '0;
  int glog[$], gstart_log[$], tlog[$];
  logic [W-1:0] dlog[$];

  task automatic reset_model();
    cyc = 0; last_g = N - 1; start_c = -1000; wait_end = -1000; gap_c = -1000;
    free_at = 0; done_c = -1000; exp_gid = 0; exp_data = '0; to_flag = 0;
  endtask

  function automatic int pick_lat();
    int r;
    if (lat_mode >= 0) return lat_mode;
    r = int'($urandom % 10);
    if (r == 0) return NEVER;
    if (r == 1) return TO;
    if (r == 2) return int'($urandom_range(1, TO - 1));
    return int'($urandom_range(8, 16));
  endfunction

  task automatic step();
    bit idle, in_wait;
    int win, lat, idx;
    logic [N-1:0] exp_ready;
    @(posedge clk); #1;
    if (auto_gen) begin
      for (int i = 0; i < N; i++) begin
        if (!vld[i]) begin
          if ($urandom % 3 == 0) begin vld[i] = 1'b1; word[i] = W'($urandom); end
        end else if ($urandom % 40 == 0) vld[i] = 1'b0;
      end
    end
    in_wait = (cyc > start_c) && (cyc <= wait_end);
    done = (cyc == done_c) || (!in_wait && spurious && ($urandom % 6 == 0));
    for (int i = 0; i < N; i++) data[i*W +: W] = word[i];
    valid = vld;
    #3;
    idle = (cyc >= free_at);
    win = -1;
    if (idle) begin
      for (int k = 1; k <= N; k++) begin
        idx = (last_g + k) % N;
        if (vld[idx] && win < 0) win = idx;
      end
    end
    exp_ready = (win >= 0) ? N'(1) << win : '0;
    check_eq("req_ready", ready, exp_ready);
    check_eq("uart_start", start, cyc == start_c);
    check_eq("busy", busy, !idle);
    check_eq("timeout_err", terr, to_flag && (cyc == gap_c));
    check_eq("uart_data", udata, exp_data);
    check_eq("grant_id", gid, exp_gid);
    if (start === 1'b1) begin glog.push_back(int'(gid)); gstart_log.push_back(cyc); dlog.push_back(udata); end
    if (terr === 1'b1) tlog.push_back(cyc);
    if (win >= 0) begin
      lat = pick_lat();
      start_c = cyc + 1;
      if (lat <= TO) begin wait_end = start_c + lat; done_c = wait_end; to_flag = 0; end
      else begin wait_end = start_c + TO; done_c = -1000; to_flag = 1; end
      gap_c = wait_end + 1;
      free_at = gap_c + 1;
      exp_data = word[win];
      exp_gid = win;
      last_g = win;
      if (!keep_valid) vld[win] = 1'b0;
    end
    cyc++;
  endtask

  task automatic drain();
    int b = 300;
    while (cyc <= free_at && b > 0) begin step(); b--; end
    check_eq("drain_idle", busy, 1'b0);
  endtask

  task automatic wait_grants(input int n, input int budget);
    while (glog.size() < n && budget > 0) begin step(); budget--; end
    check_eq("grants_seen", glog.size(), n);
  endtask

  task automatic clear_logs();
    glog.delete(); gstart_log.delete(); tlog.delete(); dlog.delete();
  endtask

  task automatic reset_outputs_check(input string tag);
    check_eq({tag, "_start"}, start, 1'b0);
    check_eq({tag, "_busy"}, busy, 1'b0);
    check_eq({tag, "_gid"}, gid, '0);
    check_eq({tag, "_ready"}, ready, '0);
    check_eq({tag, "_terr"}, terr, 1'b0);
    check_eq({tag, "_data"}, udata, '0);
  endtask

  initial begin
    keep_valid = 0; auto_gen = 0; spurious = 0; lat_mode = 12;
    for (int i = 0; i < N; i++) word[i] = '0;
    reset_model();
    #2 reset_outputs_check("por");
    @(posedge clk); #3 rst = 1'b0;
    reset_model();

    // Single request from requester 2.
    clear_logs();
    vld = 4'b0100; word[2] = 8'h5A;
    wait_grants(1, 10);
    drain();
    check_eq("single_gid", glog.size() > 0 ? glog[0] : -1, 2);
    check_eq("single_data", dlog.size() > 0 ? dlog[0] : 8'h00, 8'h5A);
    check_eq("single_pulses", gstart_log.size(), 1);

    // Reset asserted asynchronously in the middle of WAIT.
    clear_logs();
    vld[1] = 1'b1; word[1] = 8'h77;
    wait_grants(1, 10);
    repeat (4) step();
    vld = '0; valid = '0; done = 1'b0;
    #1 rst = 1'b1;
    #1 reset_outputs_check("midrst");
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    reset_model();

    // All requesters held valid: grants rotate 0,1,2,3,0 on a 15-cycle period.
    clear_logs();
    keep_valid = 1;
    vld = '1;
    for (int i = 0; i < N; i++) word[i] = W'(8'hA0 + i);
    wait_grants(5, 120);
    vld = '0; keep_valid = 0;
    drain();
    for (int i = 0; i < 5 && i < glog.size(); i++) begin
      check_eq("rr_order", glog[i], i % N);
      check_eq("rr_word", dlog[i], W'(8'hA0 + (i % N)));
      if (i > 0) check_eq("rr_period", gstart_log[i] - gstart_log[i-1], 15);
    end

    // Skip fairness: after requester 1, only 0 and 3 request.
    clear_logs();
    vld[1] = 1'b1; word[1] = 8'h11;
    wait_grants(1, 10);
    drain();
    clear_logs();
    vld = 4'b1001; word[0] = 8'hC0; word[3] = 8'hC3;
    wait_grants(2, 60);
    drain();
    if (glog.size() == 2) begin
      check_eq("fair_first", glog[0], 3);
      check_eq("fair_second", glog[1], 0);
    end

    // Silent UART: watchdog aborts, then a fresh request is still served.
    clear_logs();
    lat_mode = NEVER;
    vld[1] = 1'b1; word[1] = 8'h33;
    wait_grants(1, 10);
    drain();
    check_eq("to_pulses", tlog.size(), 1);
    if (tlog.size() == 1 && gstart_log.size() == 1)
      check_eq("to_delay", tlog[0] - gstart_log[0], TO + 1);
    lat_mode = 12;
    vld[2] = 1'b1; word[2] = 8'h44;
    wait_grants(2, 10);
    drain();

    // done arriving in the watchdog's final cycle wins over the abort.
    clear_logs();
    lat_mode = TO;
    vld[0] = 1'b1; word[0] = 8'h55;
    wait_grants(1, 10);
    drain();
    check_eq("collide_no_err", tlog.size(), 0);

    // Randomized traffic with variable UART latency and stray done pulses.
    lat_mode = -1; auto_gen = 1; spurious = 1;
    repeat (1500) step();
    auto_gen = 0; spurious = 0; vld = '0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
